ball_coord_filter: RTL and testbench

//   Consumes coordinates parsed from the K210 Bluetooth UART link (k210_xpos/k210_ypos/k210_coor_flag)
//   and turns them into a stable ball position for the OV5640 overlay path. It does range checking,

---
 rtl/ball_coord_filter_pkg.sv | 27 ++
 rtl/ball_coord_filter_ring_avg.sv | 41 ++++
 rtl/ball_coord_filter.sv | 146 ++++++++++++++
 tb/tb_ball_coord_filter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_coord_filter_pkg.sv
// Shared constants, state encoding and helpers for the K210 ball
// coordinate filter.
package ball_coord_filter_pkg;

  localparam int COORD_W  = 10;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int AVG_LOG2 = 2;

  localparam logic [COORD_W-1:0] JUMP_MAX  = 10'd120;
  localparam logic [2:0]         REJ_LIMIT = 3'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    TRACK = 2'b10
  } state_t;

  function automatic logic [COORD_W:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic [COORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[COORD_W] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/ball_coord_filter_ring_avg.sv
// Per-axis N-entry ring with running sum; avg is the truncated mean.
// Preload fills every slot with one sample for instant acquisition.
module coord_ring_avg
  import ball_coord_filter_pkg::*;
#(
  parameter int LOG2 = AVG_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               preload,
  input  logic               accept,
  input  logic [COORD_W-1:0] sample,
  output logic [COORD_W-1:0] avg
);

  localparam int N  = 1 << LOG2;
  localparam int SW = COORD_W + LOG2;

  logic [COORD_W-1:0] ring [N];
  logic [LOG2-1:0]    wr_ptr;
  logic [SW-1:0]      sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ring[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (preload) begin
      for (int i = 0; i < N; i++) ring[i] <= sample;
      wr_ptr <= '0;
      sum    <= SW'(sample) << LOG2;
    end else if (accept) begin
      ring[wr_ptr] <= sample;
      wr_ptr       <= wr_ptr + 1'b1;
      sum          <= sum + SW'(sample) - SW'(ring[wr_ptr]);
    end
  end

  assign avg = sum[SW-1:LOG2];

endmodule

// File: rtl/ball_coord_filter.sv
// Filters K210 UART ball coordinates: range check, outlier rejection,
// moving average, loss timeout and a vsync-aligned output latch.
module ball_coord_filter
  import ball_coord_filter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] k210_xpos,
  input  logic [COORD_W-1:0] k210_ypos,
  input  logic               k210_coor_flag,
  input  logic               vsync,
  output logic [COORD_W-1:0] avg_x,
  output logic [COORD_W-1:0] avg_y,
  output logic               upd_pulse,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               ball_valid,
  output logic [7:0]         err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);

  state_t             state, state_nxt;
  logic               coor_d, cap_vld, chk_vld, vsync_d;
  logic [COORD_W-1:0] raw_x, raw_y;
  logic [TW-1:0]      timer;
  logic [2:0]         rej_cnt;
  logic               in_range, near, preload, accept;
  logic               outlier, drop;

  // parser data settles one cycle after its flag rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coor_d  <= 1'b1;
      cap_vld <= 1'b0;
      chk_vld <= 1'b0;
      raw_x   <= '0;
      raw_y   <= '0;
    end else begin
      coor_d  <= k210_coor_flag;
      cap_vld <= k210_coor_flag & ~coor_d;
      chk_vld <= cap_vld;
      if (cap_vld) begin
        raw_x <= k210_xpos;
        raw_y <= k210_ypos;
      end
    end
  end

  assign in_range = (raw_x < X_LIM) && (raw_y < Y_LIM);
  assign near = (abs_diff(raw_x, avg_x) <= {1'b0, JUMP_MAX})
             && (abs_diff(raw_y, avg_y) <= {1'b0, JUMP_MAX});

  always_comb begin
    state_nxt = state;
    preload   = 1'b0;
    accept    = 1'b0;
    outlier   = 1'b0;
    drop      = chk_vld & ~in_range;
    unique case (1'b1)
      state[0]: begin
        if (chk_vld && in_range) begin
          preload   = 1'b1;
          state_nxt = TRACK;
        end
      end
      state[1]: begin
        if (chk_vld && in_range && near) begin
          accept = 1'b1;
        end else begin
          if (chk_vld && in_range) begin
            outlier = 1'b1;
            preload = (rej_cnt == REJ_LIMIT - 3'd1);
          end
          if (!preload && timer == T_LAST)
            state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      timer     <= '0;
      rej_cnt   <= '0;
      upd_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      upd_pulse <= preload | accept;
      if (preload || accept || state_nxt == EMPTY)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (preload || accept || state_nxt == EMPTY)
        rej_cnt <= '0;
      else if (outlier)
        rej_cnt <= rej_cnt + 3'd1;
      if (drop && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  coord_ring_avg u_ring_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .preload (preload),
    .accept  (accept),
    .sample  (raw_x),
    .avg     (avg_x)
  );

  coord_ring_avg u_ring_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .preload (preload),
    .accept  (accept),
    .sample  (raw_y),
    .avg     (avg_y)
  );

  // avg regs still hold the pre-update value on a coincident edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d    <= 1'b0;
      ball_x     <= '0;
      ball_y     <= '0;
      ball_valid <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (vsync && !vsync_d) begin
        ball_x     <= avg_x;
        ball_y     <= avg_y;
        ball_valid <= (state == TRACK);
      end
    end
  end

endmodule

// File: tb/tb_ball_coord_filter.sv
// Randomised scoreboard bench for ball_coord_filter with a
// queue-based reference model of the smoothing/tracking rules.
module tb_ball_coord_filter;

  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag = 1'b1;
  logic       vsync = 1'b0;
  logic [9:0] xpos = '0;
  logic [9:0] ypos = '0;
  logic [9:0] avg_x, avg_y, ball_x, ball_y;
  logic       upd_pulse, ball_valid;
  logic [7:0] err_cnt;

  ball_coord_filter #(.TIMEOUT_CYC(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .k210_xpos      (xpos),
    .k210_ypos      (ypos),
    .k210_coor_flag (flag),
    .vsync          (vsync),
    .avg_x          (avg_x),
    .avg_y          (avg_y),
    .upd_pulse      (upd_pulse),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_valid     (ball_valid),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [19:0] expq[$];
  int  mq_x[$], mq_y[$];
  bit  trk;
  int  rej, err, m_l;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int qavg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / 4;
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic m_preload(input int x, input int y, input int c);
    mq_x.delete();
    mq_y.delete();
    for (int i = 0; i < 4; i++) begin
      mq_x.push_back(x);
      mq_y.push_back(y);
    end
    trk = 1;
    rej = 0;
    m_l = c;
  endtask

  task automatic m_step(input int x, input int y, input int c);
    int ax, ay;
    if (x >= 640 || y >= 480) begin
      if (err < 255) err++;
      return;
    end
    if (trk && (c - m_l) > T) trk = 0;
    ax = qavg(mq_x);
    ay = qavg(mq_y);
    if (!trk) begin
      m_preload(x, y, c);
    end else if (iabs(x - ax) <= 120 && iabs(y - ay) <= 120) begin
      void'(mq_x.pop_front());
      void'(mq_y.pop_front());
      mq_x.push_back(x);
      mq_y.push_back(y);
      rej = 0;
      m_l = c;
    end else begin
      rej++;
      if (rej < 3) return;
      m_preload(x, y, c);
    end
    expq.push_back({10'(qavg(mq_x)), 10'(qavg(mq_y))});
  endtask

  task automatic m_reset();
    mq_x.delete();
    mq_y.delete();
    trk = 0;
    rej = 0;
    err = 0;
    m_l = 0;
    expq.delete();
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && upd_pulse) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_unexpected: got avg (%0d,%0d) expected none",
                 avg_x, avg_y);
      end else begin
        e = expq.pop_front();
        chk("sb_avg_x", int'(avg_x), int'(e[19:10]));
        chk("sb_avg_y", int'(avg_y), int'(e[9:0]));
      end
    end
  end

  task automatic send(input int x, input int y);
    @(negedge clk);
    xpos = 10'(x);
    ypos = 10'(y);
    flag = 1'b0;
    @(negedge clk);
    flag = 1'b1;
    m_step(x, y, cyc + 3);
    repeat (5) @(negedge clk);
    chk("sb_drain", expq.size(), 0);
  endtask

  task automatic send_at(input int x, input int y, input int target);
    while (cyc < target - 5) @(negedge clk);
    send(x, y);
  endtask

  task automatic do_vsync();
    int v, ev, ex, ey;
    @(negedge clk);
    vsync = 1'b1;
    v  = cyc + 1;
    ev = (trk && (v - m_l) <= T) ? 1 : 0;
    ex = qavg(mq_x);
    ey = qavg(mq_y);
    @(negedge clk);
    vsync = 1'b0;
    chk("ball_valid", int'(ball_valid), ev);
    chk("ball_x", int'(ball_x), ex);
    chk("ball_y", int'(ball_y), ey);
    chk("err_cnt", int'(err_cnt), err);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_avg_x"}, int'(avg_x), 0);
    chk({tag, "_avg_y"}, int'(avg_y), 0);
    chk({tag, "_ball_x"}, int'(ball_x), 0);
    chk({tag, "_ball_y"}, int'(ball_y), 0);
    chk({tag, "_valid"}, int'(ball_valid), 0);
    chk({tag, "_upd"}, int'(upd_pulse), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flag  = 1'b1;
    vsync = 1'b0;
    m_reset();
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, x, y, ax, ay;
    m_reset();
    do_reset();

    repeat (3) do_vsync();

    send(320, 240);
    chk("t2_avg_x", int'(avg_x), 320);
    chk("t2_avg_y", int'(avg_y), 240);
    do_vsync();
    chk("t2_valid", int'(ball_valid), 1);

    do_reset();
    send(100, 100);
    send(104, 100); chk("t3_a", int'(avg_x), 101);
    send(108, 100); chk("t3_b", int'(avg_x), 103);
    send(112, 100); chk("t3_c", int'(avg_x), 106);
    send(116, 100); chk("t3_d", int'(avg_x), 110);
    chk("t3_y", int'(avg_y), 100);

    do_reset();
    send(100, 100);
    send(400, 100);
    send(400, 100);
    send(100, 100);
    chk("t4_hold", int'(avg_x), 100);
    send(400, 100);
    send(400, 100);
    chk("t4_rej", int'(avg_x), 100);
    send(400, 100);
    chk("t4_repre_x", int'(avg_x), 400);
    chk("t4_repre_y", int'(avg_y), 100);

    send(640, 10);
    send(5, 480);
    chk("t5_err2", int'(err_cnt), 2);
    do_vsync();
    for (int i = 0; i < 298; i++) send(700 + (i % 300), i % 480);
    chk("t5_sat", int'(err_cnt), 255);

    do_reset();
    send(100, 100);
    repeat (T + 5) @(negedge clk);
    do_vsync();
    chk("t6_lost", int'(ball_valid), 0);
    send(200, 200);
    send_at(210, 200, m_l + T);
    chk("t6_expiry_acc", int'(avg_x), 202);
    do_vsync();
    send_at(500, 400, m_l + T + 1);
    chk("t6_reacq", int'(avg_x), 500);

    @(negedge clk);
    xpos = 10'd300;
    ypos = 10'd300;
    flag = 1'b0;
    @(negedge clk);
    flag = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    check_zero("midrst");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_upd", int'(avg_x), 0);

    for (int i = 0; i < 500; i++) begin
      r  = $urandom_range(0, 99);
      ax = qavg(mq_x);
      ay = qavg(mq_y);
      if (r < 60) begin
        x = ax + int'($urandom_range(0, 260)) - 130;
        y = ay + int'($urandom_range(0, 260)) - 130;
        x = x < 0 ? 0 : (x > 639 ? 639 : x);
        y = y < 0 ? 0 : (y > 479 ? 479 : y);
        send(x, y);
      end else if (r < 70) begin
        send($urandom_range(0, 639), $urandom_range(0, 479));
      end else if (r < 78) begin
        if (r[0]) send($urandom_range(640, 1023), $urandom_range(0, 479));
        else      send($urandom_range(0, 639), $urandom_range(480, 1023));
      end else if (r < 90) begin
        do_vsync();
      end else if (r < 92) begin
        repeat ($urandom_range(T - 20, T + 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    do_vsync();
    chk("final_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
